// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared types and constants for the Wishbone burst initiator.
package wb_master_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      STB  = 2'd2,
      END  = 2'd3
   } state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B3 initiator turning one command into a single-CYC
// incrementing burst. Write beats stream in through wdata_*, read beats stream
// out through rdata_*.
// Optional ack watchdog: define WB_MASTER_TIMEOUT_EN (limit = TIMEOUT cycles).
module wb_burst_master
   import wb_master_pkg::*;
#(
   parameter int DW      = 32,
   parameter int AW      = 26,
   parameter int TIMEOUT = 255
) (
   input  logic            sys_clk,
   input  logic            RESET,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [3:0]      cmd_len,
   input  logic [DW/8-1:0] cmd_sel,
   input  logic            wdata_valid,
   output logic            wdata_ready,
   input  logic [DW-1:0]   wdata,
   output logic            rdata_valid,
   output logic [DW-1:0]   rdata,
   output logic            rdata_last,
   output logic            done,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic            wb_we_o,
   output logic [AW-1:0]   wb_addr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic [2:0]      wb_cti_o,
   input  logic            wb_ack_i,
   input  logic [DW-1:0]   wb_dat_i,
   output logic            err
);

   localparam int BYTES = DW / 8;

   state_t           state, state_nxt;
   logic             we_r, multi_r;
   logic [AW-1:0]    addr_r;
   logic [BYTES-1:0] sel_r;
   logic [DW-1:0]    dat_r, rdata_r;
   logic [4:0]       beats_left;
   logic             rdata_valid_r, rdata_last_r;
   logic             accept, beat, last_beat, tmo_hit;

   assign accept    = (state == IDLE) && cmd_valid;
   assign beat      = (state == STB) && wb_ack_i;
   assign last_beat = (beats_left == 5'd1);

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] tmo_cnt;
   logic          err_r;

   assign tmo_hit = (state == STB) && !wb_ack_i && (tmo_cnt == CW'(TIMEOUT - 1));

   // Ack watchdog: zero outside STB (so it starts at 0 on entry) and on every ack.
   always_ff @(posedge sys_clk or posedge RESET) begin
      if (RESET)                       tmo_cnt <= '0;
      else if (beat || state != STB)   tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + 1'b1;
   end

   // One-cycle err pulse in the cycle after the watchdog fires.
   always_ff @(posedge sys_clk or posedge RESET) begin
      if (RESET) err_r <= 1'b0;
      else       err_r <= tmo_hit;
   end

   assign err = err_r;
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

   // State register; reset clears it asynchronously so cyc/stb drop at once.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   // NOTE: the default assignment first keeps this purely combinational (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept)      state_nxt = cmd_we ? LOAD : STB;
         LOAD: if (wdata_valid) state_nxt = STB;
         STB: begin
            if (tmo_hit)        state_nxt = IDLE;
            else if (beat)      state_nxt = last_beat ? END : (we_r ? LOAD : STB);
         end
         END:                   state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // Bus-facing outputs decoded from the current state.
   always_comb begin
      cmd_ready   = (state == IDLE);
      wb_cyc_o    = (state == LOAD) || (state == STB);
      wb_stb_o    = (state == STB);
      wb_we_o     = we_r && wb_cyc_o;
      wdata_ready = (state == LOAD) && wdata_valid;
      done        = (state == END);
      wb_cti_o    = CTI_CLASSIC;
      if (wb_cyc_o && multi_r) wb_cti_o = last_beat ? CTI_EOB : CTI_INCR;
   end

   // Command latch, address/beat counters and write data holding register.
   always_ff @(posedge sys_clk or posedge RESET) begin
      if (RESET) begin
         we_r       <= 1'b0;
         multi_r    <= 1'b0;
         addr_r     <= '0;
         sel_r      <= '0;
         beats_left <= '0;
         dat_r      <= '0;
      end else begin
         if (accept) begin
            we_r       <= cmd_we;
            multi_r    <= (cmd_len != 4'd0);
            addr_r     <= cmd_addr;
            sel_r      <= cmd_sel;
            beats_left <= {1'b0, cmd_len} + 5'd1;
         end
         if ((state == LOAD) && wdata_valid) dat_r <= wdata;
         if (beat) begin
            addr_r     <= addr_r + AW'(BYTES);
            beats_left <= beats_left - 5'd1;
         end
      end
   end

   // Read return path: one registered beat per read ack, no backpressure.
   always_ff @(posedge sys_clk or posedge RESET) begin
      if (RESET) begin
         rdata_valid_r <= 1'b0;
         rdata_last_r  <= 1'b0;
         rdata_r       <= '0;
      end else begin
         rdata_valid_r <= beat && !we_r;
         rdata_last_r  <= beat && !we_r && last_beat;
         if (beat && !we_r) rdata_r <= wb_dat_i;
      end
   end

   assign wb_addr_o   = addr_r;
   assign wb_dat_o    = dat_r;
   assign wb_sel_o    = sel_r;
   assign rdata       = rdata_r;
   assign rdata_valid = rdata_valid_r;
   assign rdata_last  = rdata_last_r;

endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: self-checking bench for wb_burst_master.
// A Wishbone slave model with programmable ack latency answers the bursts; a
// scoreboard built from the burst rules (address stride, cti pattern, beat
// count) checks every strobe, every read return and every done pulse.
module tb_wb_burst_master;

   localparam int DW  = 32;
   localparam int AW  = 26;
   localparam int TMO = 8;

   logic          sys_clk, RESET;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [3:0]    cmd_len, cmd_sel;
   logic          wdata_valid, wdata_ready;
   logic [DW-1:0] wdata, rdata;
   logic          rdata_valid, rdata_last, done;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [AW-1:0] wb_addr_o;
   logic [DW-1:0] wb_dat_o, wb_dat_i;
   logic [3:0]    wb_sel_o;
   logic [2:0]    wb_cti_o;
   logic          wb_ack_i, err;

   wb_burst_master #(.DW(DW), .AW(AW), .TIMEOUT(TMO)) dut (
      .sys_clk(sys_clk), .RESET(RESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
      .done(done),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
      .err(err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_event(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event seen, required none", name);
   endtask

   // ---------------- reference scoreboard ----------------
   typedef struct {
      logic [AW-1:0] addr;
      logic [2:0]    cti;
      logic [3:0]    sel;
      logic          we;
      logic [31:0]   dat;
      logic          last;
   } beat_t;

   typedef struct {
      logic [31:0] dat;
      logic        last;
   } rd_t;

   beat_t       exp_beats[$];
   rd_t         exp_rd[$];
   logic [31:0] wd_buf[16];

   // ---------------- slave model ----------------
   int   slv_lat  = 0;
   logic spurious = 1'b0;
   logic slv_hang = 1'b0;
   int   wcnt     = 0;

   // Drives ack/data 2 time units after each rising edge; lat=0 gives back-to-back acks.
   always @(posedge sys_clk) begin
      #2;
      if (RESET) begin
         wb_ack_i = 1'b0;
         wcnt     = 0;
      end else if (!(wb_cyc_o && wb_stb_o)) begin
         wb_ack_i = spurious;
         wcnt     = 0;
      end else if (wb_ack_i && slv_lat != 0) begin
         wb_ack_i = 1'b0;
         wcnt     = 0;
      end else if (!slv_hang && wcnt >= slv_lat) begin
         wb_ack_i = 1'b1;
         wb_dat_i = $urandom;
      end else begin
         wcnt++;
      end
   end

   // ---------------- monitor ----------------
   int            n_done = 0;
   logic          in_burst = 1'b0;
   int            obs_beats = 0;
   logic [2:0]    obs_first_cti, obs_last_cti;
   logic [AW-1:0] obs_last_addr;
   beat_t         mon_b;
   rd_t           mon_r;

   always @(negedge sys_clk) begin
      if (RESET) begin
         in_burst = 1'b0;
      end else begin
         if (in_burst && !err) begin
            check("cyc_continuous", wb_cyc_o, !done);
            check("ready_busy", cmd_ready, 1'b0);
         end
`ifndef WB_MASTER_TIMEOUT_EN
         check("err_tied_low", err, 1'b0);
`endif
         if (wb_cyc_o && wb_stb_o) begin
            if (exp_beats.size() == 0) begin
               fail_event("unexpected_strobe");
            end else begin
               mon_b = exp_beats[0];
               check("beat_addr", wb_addr_o, mon_b.addr);
               check("beat_cti", wb_cti_o, mon_b.cti);
               check("beat_sel", wb_sel_o, mon_b.sel);
               check("beat_we", wb_we_o, mon_b.we);
               if (mon_b.we) check("beat_wdat", wb_dat_o, mon_b.dat);
               if (wb_ack_i) begin
                  void'(exp_beats.pop_front());
                  if (!mon_b.we) begin
                     mon_r.dat  = wb_dat_i;
                     mon_r.last = mon_b.last;
                     exp_rd.push_back(mon_r);
                  end
                  if (obs_beats == 0) obs_first_cti = wb_cti_o;
                  obs_last_cti  = wb_cti_o;
                  obs_last_addr = wb_addr_o;
                  obs_beats++;
               end
            end
         end
         if (rdata_valid) begin
            if (exp_rd.size() == 0) begin
               fail_event("unexpected_rdata");
            end else begin
               mon_r = exp_rd.pop_front();
               check("rdata", rdata, mon_r.dat);
               check("rdata_last", rdata_last, mon_r.last);
            end
         end else if (rdata_last) begin
            fail_event("rdata_last_without_valid");
         end
         if (done) begin
            n_done++;
            in_burst = 1'b0;
         end
         if (err) in_burst = 1'b0;
         if (cmd_valid && cmd_ready) begin
            in_burst  = 1'b1;
            obs_beats = 0;
         end
      end
   end

   // ---------------- driver tasks (entered/left at posedge+1) ----------------
   task automatic issue_cmd(input logic we, input logic [AW-1:0] addr, input logic [3:0] len,
                            input logic [3:0] sel, input logic rnd);
      beat_t b;
      logic  ok;
      for (int i = 0; i <= int'(len); i++) begin
         wd_buf[i] = rnd ? $urandom : 32'(i + 1);
         b.addr = addr + AW'(4 * i);
         b.cti  = (len == 4'd0) ? 3'b000 : ((i == int'(len)) ? 3'b111 : 3'b010);
         b.sel  = sel;
         b.we   = we;
         b.dat  = wd_buf[i];
         b.last = (i == int'(len));
         exp_beats.push_back(b);
      end
      cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_sel = sel; cmd_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge sys_clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge sys_clk); #1;
      end
      @(posedge sys_clk); #1;
      cmd_valid = 1'b0;
      cmd_we    = ~we;
      cmd_addr  = AW'($urandom);
      cmd_len   = 4'($urandom);
      cmd_sel   = ~sel;
      check("cmd_accepted", ok, 1'b1);
   endtask

   task automatic feed_writes(input logic [3:0] len, input int lat, input int stall_beat,
                              input int stall_len);
      logic hs;
      for (int i = 0; i <= int'(len); i++) begin
         if (i == stall_beat) begin
            wdata_valid = 1'b0;
            spurious    = 1'b1;
            for (int k = 0; k < stall_len; k++) begin
               @(negedge sys_clk);
               if (k >= lat + 1) begin
                  check("stall_stb_low", wb_stb_o, 1'b0);
                  check("stall_cyc_high", wb_cyc_o, 1'b1);
               end
               @(posedge sys_clk); #1;
            end
            spurious = 1'b0;
         end
         wdata_valid = 1'b1;
         wdata       = wd_buf[i];
         hs          = 1'b0;
         for (int k = 0; k < 100; k++) begin
            @(negedge sys_clk);
            hs = wdata_ready;
            @(posedge sys_clk); #1;
            if (hs) break;
         end
         check("wdata_accepted", hs, 1'b1);
      end
      wdata_valid = 1'b0;
      wdata       = $urandom;
   endtask

   task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input logic [3:0] len,
                          input logic [3:0] sel, input int lat, input int stall_beat,
                          input int stall_len, input logic rnd);
      int   d0;
      logic seen;
      slv_lat = lat;
      d0      = n_done;
      issue_cmd(we, addr, len, sel, rnd);
      if (we) feed_writes(len, lat, stall_beat, stall_len);
      seen = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge sys_clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      @(posedge sys_clk); #1;
      check("done_seen", seen, 1'b1);
      check("beats_all_issued", exp_beats.size(), 0);
      check("reads_all_returned", exp_rd.size(), 0);
      @(negedge sys_clk);
      check("single_done_pulse", n_done - d0, 1);
      @(posedge sys_clk); #1;
      exp_beats.delete();
      exp_rd.delete();
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [3:0]    len;
      logic [3:0]    sel;
      int            lat;
      int            stall_beat;
      int            stall_len;
      int            exp_beats;
      logic [2:0]    exp_first_cti;
      logic [2:0]    exp_last_cti;
      logic [AW-1:0] exp_last_addr;
   } vec_t;

   vec_t vecs[7];

   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [3:0]    r_len, r_sel;
   logic [31:0]   r_tmp;
   int            r_lat, r_stall, r_slen, d0, cnt;
   logic          seen;

   initial begin : main
      vecs[0] = '{1'b0, 26'h0000100, 4'd0,  4'hF, 2, -1, 0, 1,  3'b000, 3'b000, 26'h0000100};
      vecs[1] = '{1'b1, 26'h0000200, 4'd3,  4'hF, 1, -1, 0, 4,  3'b010, 3'b111, 26'h000020C};
      vecs[2] = '{1'b1, 26'h0000300, 4'd3,  4'h3, 0,  2, 5, 4,  3'b010, 3'b111, 26'h000030C};
      vecs[3] = '{1'b0, 26'h3FFFFFC, 4'd1,  4'hF, 0, -1, 0, 2,  3'b010, 3'b111, 26'h0000000};
      vecs[4] = '{1'b0, 26'h0000040, 4'd15, 4'hC, 0, -1, 0, 16, 3'b010, 3'b111, 26'h000007C};
      vecs[5] = '{1'b1, 26'h3FFFFF8, 4'd3,  4'h1, 3,  0, 6, 4,  3'b010, 3'b111, 26'h0000004};
      vecs[6] = '{1'b1, 26'h0000010, 4'd0,  4'h8, 0, -1, 0, 1,  3'b000, 3'b000, 26'h0000010};

      RESET = 1'b1;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_sel = '0;
      wdata_valid = 1'b0; wdata = '0; wb_ack_i = 1'b0; wb_dat_i = '0;

      #2;
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_bus_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o}, 6'b0);
      check("rst_bus_addr_sel", {wb_addr_o, wb_sel_o}, '0);
      check("rst_bus_dat", wb_dat_o, '0);
      check("rst_stream", {wdata_ready, rdata_valid, rdata_last, done, err}, 5'b0);
      check("rst_rdata", rdata, '0);

      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      RESET = 1'b0;
      @(posedge sys_clk); #1;
      check("post_rst_ready", cmd_ready, 1'b1);

      for (int v = 0; v < 7; v++) begin
         run_cmd(vecs[v].we, vecs[v].addr, vecs[v].len, vecs[v].sel, vecs[v].lat,
                 vecs[v].stall_beat, vecs[v].stall_len, 1'b0);
         check("vec_beats", obs_beats, vecs[v].exp_beats);
         check("vec_first_cti", obs_first_cti, vecs[v].exp_first_cti);
         check("vec_last_cti", obs_last_cti, vecs[v].exp_last_cti);
         check("vec_last_addr", obs_last_addr, vecs[v].exp_last_addr);
      end

      // Reset in the middle of a 4-beat read, while beat 2 is being acknowledged.
      slv_lat = 2;
      issue_cmd(1'b0, 26'h0000500, 4'd3, 4'hF, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge sys_clk); #1;
         if (obs_beats >= 2) begin
            seen = 1'b1;
            break;
         end
      end
      check("reset_beat2_reached", seen, 1'b1);
      #2;
      check("pre_reset_cyc", wb_cyc_o, 1'b1);
      RESET = 1'b1;
      #1;
      check("async_rst_cyc", wb_cyc_o, 1'b0);
      check("async_rst_stb", wb_stb_o, 1'b0);
      check("async_rst_done", done, 1'b0);
      check("async_rst_ready", cmd_ready, 1'b1);
      @(negedge sys_clk);
      @(negedge sys_clk);
      #1;
      RESET = 1'b0;
      exp_beats.delete();
      exp_rd.delete();
      @(posedge sys_clk); #1;
      check("after_rst_ready", cmd_ready, 1'b1);
      check("after_rst_idle", {wb_cyc_o, done}, 2'b00);
      run_cmd(1'b1, 26'h0000600, 4'd1, 4'h5, 1, -1, 0, 1'b1);
      check("after_rst_beats", obs_beats, 2);

`ifdef WB_MASTER_TIMEOUT_EN
      // Slave never acks: watchdog must abort after TMO cycles in STB.
      slv_hang = 1'b1;
      d0 = n_done;
      issue_cmd(1'b0, 26'h0000700, 4'd3, 4'hF, 1'b1);
      cnt  = 0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge sys_clk);
         cnt++;
         if (err) begin
            seen = 1'b1;
            break;
         end
      end
      check("tmo_err_seen", seen, 1'b1);
      check("tmo_cycles", cnt, TMO + 1);
      check("tmo_cyc_low", wb_cyc_o, 1'b0);
      check("tmo_ready", cmd_ready, 1'b1);
      @(negedge sys_clk);
      check("tmo_err_pulse", err, 1'b0);
      check("tmo_no_done", n_done - d0, 0);
      @(posedge sys_clk); #1;
      slv_hang = 1'b0;
      exp_beats.delete();
      exp_rd.delete();
`endif

      // Randomized bursts against the scoreboard.
      for (int r = 0; r < 24; r++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_tmp  = $urandom;
         r_addr = {r_tmp[AW-1:2], 2'b00};
         if (r % 6 == 0) r_addr = 26'h3FFFFF0;
         r_len  = 4'($urandom_range(0, 15));
         r_sel  = 4'($urandom_range(1, 15));
         r_lat  = $urandom_range(0, 3);
         r_stall = (r_we && $urandom_range(0, 1) == 1) ? $urandom_range(0, int'(r_len)) : -1;
         r_slen = $urandom_range(1, 6);
         run_cmd(r_we, r_addr, r_len, r_sel, r_lat, r_stall, r_slen, 1'b1);
         check("rand_beats", obs_beats, int'(r_len) + 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
